// File: rtl/axi4_frame_reader_if.sv
// AXI4 read-channel bundle (AR + R) between the frame reader and the DDR interconnect.
// master drives AR and RREADY; slave returns R data and ARREADY.
`timescale 1ns/1ps
interface axi4_frame_reader_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic [3:0]        ARCACHE;
  logic [2:0]        ARPROT;
  logic [DATA_W-1:0] RDATA;
  logic              RVALID;
  logic              RREADY;
  logic              RLAST;
  logic [1:0]        RRESP;

  modport master (
    output ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT, RREADY,
    input  ARREADY, RDATA, RVALID, RLAST, RRESP
  );

  modport slave (
    input  ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT, RREADY,
    output ARREADY, RDATA, RVALID, RLAST, RRESP
  );
endinterface

// File: rtl/axi4_frame_reader.sv
// AXI4 read master: fetches one 320x240 RGB565 frame as 300 INCR bursts of 64 beats and
// streams the beats to an external dual-clock FIFO. Handshakes: a transfer happens on a
// clock edge where VALID and READY are both high; VALID never drops before that edge.
`timescale 1ns/1ps
module axi4_frame_reader #(
  parameter int                        AXI_ADDR_WIDTH   = 32,
  parameter int                        AXI_DATA_WIDTH   = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR  = 32'h0100_0000,
  parameter int                        BURSTS_PER_FRAME = 300,
  parameter int                        BURST_BYTES      = 512
) (
  input  logic                      clk_100Mhz,
  input  logic                      rst,
  input  logic                      frame_start,
  axi4_frame_reader_if.master       axi,
  output logic [AXI_DATA_WIDTH-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_prog_full,
  output logic [8:0]                burst_count,
  output logic                      rd_error,
  output logic [1:0]                state
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ADDR_SEND  = 2'd1,
    DATA_RECV  = 2'd2,
    WAIT_FRAME = 2'd3
  } state_t;

  localparam logic [8:0]                LAST_BURST = 9'(BURSTS_PER_FRAME);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP  = AXI_ADDR_WIDTH'(BURST_BYTES);

  state_t                    state_q, state_d;
  logic                      arvalid_q, arvalid_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [8:0]                bcnt_q, bcnt_d;
  logic [5:0]                beat_q, beat_d;
  logic                      err_q, err_d;
  logic                      armed_q, armed_d;
  logic                      pend_q, pend_d;
  logic [2:0]                sync_q;
  logic                      sof;
  logic                      rready;
  logic                      beat_acc;

  // Two synchroniser flops, then a third copy for rising-edge detection.
  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) sync_q <= 3'b000;
    else     sync_q <= {sync_q[1:0], frame_start};
  end
  assign sof = sync_q[1] & ~sync_q[2];

  assign rready   = (state_q == DATA_RECV);
  assign beat_acc = rready & axi.RVALID;

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= FRAME_BASE_ADDR;
      bcnt_q    <= 9'd0;
      beat_q    <= 6'd0;
      err_q     <= 1'b0;
      armed_q   <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      bcnt_q    <= bcnt_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      armed_q   <= armed_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    bcnt_d    = bcnt_q;
    beat_d    = beat_q;
    err_d     = err_q;
    armed_d   = armed_q;
    pend_d    = pend_q;
    case (state_q)
      IDLE: begin
        if (sof) begin
          bcnt_d   = 9'd0;
          araddr_d = FRAME_BASE_ADDR;
          armed_d  = 1'b1;
        end else if (!armed_q || bcnt_q == LAST_BURST) begin
          state_d = WAIT_FRAME;
          armed_d = 1'b0;
        end else if (!out_prog_full) begin
          state_d = ADDR_SEND;
        end
      end
      ADDR_SEND: begin
        if (sof) pend_d = 1'b1;
        if (!arvalid_q) begin
          arvalid_d = 1'b1;
        end else if (axi.ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = DATA_RECV;
        end
      end
      DATA_RECV: begin
        if (sof) pend_d = 1'b1;
        if (beat_acc) begin
          beat_d = beat_q + 6'd1;
          if (axi.RRESP != 2'b00 || axi.RLAST != (beat_q == 6'd63)) err_d = 1'b1;
          // The 64th beat closes the burst even if RLAST was missing or early.
          if (beat_q == 6'd63) begin
            beat_d  = 6'd0;
            state_d = IDLE;
            if (pend_q || sof) begin
              bcnt_d   = 9'd0;
              araddr_d = FRAME_BASE_ADDR;
              pend_d   = 1'b0;
            end else begin
              bcnt_d   = bcnt_q + 9'd1;
              araddr_d = araddr_q + ADDR_STEP;
            end
          end
        end
      end
      WAIT_FRAME: begin
        if (sof) begin
          bcnt_d   = 9'd0;
          araddr_d = FRAME_BASE_ADDR;
          armed_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign axi.ARADDR  = araddr_q;
  assign axi.ARVALID = arvalid_q;
  assign axi.ARLEN   = 8'd63;
  assign axi.ARSIZE  = 3'b011;
  assign axi.ARBURST = 2'b01;
  assign axi.ARCACHE = 4'b1111;
  assign axi.ARPROT  = 3'b010;
  assign axi.RREADY  = rready;

  assign out_data    = axi.RDATA;
  assign out_valid   = beat_acc;
  assign burst_count = bcnt_q;
  assign rd_error    = err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_axi4_frame_reader.sv
// Directed self-checking bench for axi4_frame_reader with a responding AXI memory model
// and an expected-beat queue filled as read data is driven.
`timescale 1ns/1ps
module tb_axi4_frame_reader;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk_100Mhz = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        out_prog_full = 1'b0;
  logic [63:0] out_data;
  logic        out_valid;
  logic [8:0]  burst_count;
  logic        rd_error;
  logic [1:0]  state;

  axi4_frame_reader_if bus ();

  axi4_frame_reader dut (
    .clk_100Mhz    (clk_100Mhz),
    .rst           (rst),
    .frame_start   (frame_start),
    .axi           (bus),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_prog_full (out_prog_full),
    .burst_count   (burst_count),
    .rd_error      (rd_error),
    .state         (state)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  int total = 0;
  int bad   = 0;

  // Memory model knobs, set by the directed sequence.
  int ar_delay        = 0;
  int rlast_bad_burst = -1;
  int rresp_bad_burst = -1;

  logic [63:0] exp_q[$];
  logic [31:0] ar_log[$];
  int          arv_len_log[$];
  int          beats_at_hs[$];
  logic [8:0]  bc_at_hs[$];
  int          beats_total = 0;
  int          mon_beat = 0;
  int          arv_cnt = 0;
  int          arv_unstable = 0;
  logic [31:0] arv_first_addr = '0;

  // ---------------- memory model (slave side) ----------------
  logic        s_hs, s_acc, s_arv;
  logic [31:0] s_addr;
  logic [31:0] m_addr;
  logic        m_active = 1'b0;
  int          m_beat = 0;
  int          m_idx = 0;
  int          m_cur = 0;
  int          ar_hi = 0;
  logic [63:0] m_data;

  always @(posedge clk_100Mhz) begin
    s_hs   = bus.ARVALID && bus.ARREADY;
    s_acc  = bus.RVALID && bus.RREADY;
    s_arv  = bus.ARVALID;
    s_addr = bus.ARADDR;
    #1;
    if (rst) begin
      bus.RVALID  = 1'b0;
      bus.RLAST   = 1'b0;
      bus.RRESP   = 2'b00;
      bus.RDATA   = '0;
      bus.ARREADY = (ar_delay == 0);
      m_active = 1'b0;
      m_beat   = 0;
      m_idx    = 0;
      ar_hi    = 0;
    end else begin
      if (s_hs) ar_hi = 0;
      else if (s_arv) ar_hi++;
      bus.ARREADY = (ar_hi >= ar_delay);
      if (s_acc) begin
        m_beat++;
        if (m_beat == 64) m_active = 1'b0;
      end
      if (s_hs) begin
        m_active = 1'b1;
        m_beat   = 0;
        m_addr   = s_addr;
        m_cur    = m_idx;
        m_idx++;
      end
      if (m_active) begin
        if (!bus.RVALID || s_acc) begin
          m_data = {m_addr, 26'd0, 6'(m_beat)};
          exp_q.push_back(m_data);
          bus.RDATA = m_data;
          bus.RLAST = (m_cur == rlast_bad_burst) ? (m_beat == 62) : (m_beat == 63);
          bus.RRESP = (m_cur == rresp_bad_burst && m_beat == 17) ? 2'b10 : 2'b00;
        end
        bus.RVALID = 1'b1;
      end else begin
        bus.RVALID = 1'b0;
        bus.RLAST  = 1'b0;
        bus.RRESP  = 2'b00;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [63:0] exp_data;
  always @(negedge clk_100Mhz) begin
    if (!rst) begin
      if (bus.ARVALID) begin
        if (arv_cnt == 0) arv_first_addr = bus.ARADDR;
        else if (bus.ARADDR !== arv_first_addr) arv_unstable++;
        arv_cnt++;
        if (bus.ARREADY) begin
          ar_log.push_back(bus.ARADDR);
          arv_len_log.push_back(arv_cnt);
          beats_at_hs.push_back(beats_total);
          bc_at_hs.push_back(burst_count);
          arv_cnt  = 0;
          mon_beat = 0;
        end
      end
      if (out_valid) begin
        total++;
        assert (exp_q.size() > 0) else begin
          bad++;
          $error("FAIL unexpected_beat observed=%0h expected=none", out_data);
        end
        if (exp_q.size() > 0) begin
          exp_data = exp_q.pop_front();
          total++;
          assert (out_data === exp_data) else begin
            bad++;
            $error("FAIL beat_data observed=%0h expected=%0h", out_data, exp_data);
          end
        end
        beats_total++;
        mon_beat++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    exp_q.delete();
    ar_log.delete();
    arv_len_log.delete();
    beats_at_hs.delete();
    bc_at_hs.delete();
    beats_total  = 0;
    mon_beat     = 0;
    arv_cnt      = 0;
    arv_unstable = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_100Mhz);
    rst = 1'b1;
    frame_start = 1'b0;
    out_prog_full = 1'b0;
    repeat (2) @(negedge clk_100Mhz);
    clear_logs();
    rst = 1'b0;
  endtask

  task automatic sof_pulse();
    frame_start = 1'b1;
    repeat (3) @(negedge clk_100Mhz);
    frame_start = 1'b0;
  endtask

  task automatic wait_bc(input logic [8:0] tgt, input int budget, input string tag);
    int n = 0;
    while (burst_count !== tgt && n < budget) begin
      @(negedge clk_100Mhz);
      n++;
    end
    chk(tag, 64'(burst_count), 64'(tgt));
  endtask

  task automatic wait_ar(input int cnt, input int budget, input string tag);
    int n = 0;
    while (ar_log.size() < cnt && n < budget) begin
      @(negedge clk_100Mhz);
      n++;
    end
    chk(tag, 64'(ar_log.size()), 64'(cnt));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int lat;
    int arv_seen;

    // Reset state
    repeat (3) @(negedge clk_100Mhz);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_arvalid", 64'(bus.ARVALID), 64'd0);
    chk("rst_rready", 64'(bus.RREADY), 64'd0);
    chk("rst_araddr", 64'(bus.ARADDR), 64'(BASE));
    chk("rst_burst_count", 64'(burst_count), 64'd0);
    chk("rst_rd_error", 64'(rd_error), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("arlen", 64'(bus.ARLEN), 64'd63);
    chk("arsize", 64'(bus.ARSIZE), 64'd3);
    chk("arburst", 64'(bus.ARBURST), 64'd1);
    chk("arcache", 64'(bus.ARCACHE), 64'd15);
    chk("arprot", 64'(bus.ARPROT), 64'd2);
    clear_logs();
    rst = 1'b0;
    repeat (3) @(negedge clk_100Mhz);
    chk("wait_frame_after_reset", 64'(state), 64'd3);

    // Full frame
    sof_pulse();
    wait_bc(9'd300, 25000, "frame_done");
    repeat (3) @(negedge clk_100Mhz);
    chk("frame_state", 64'(state), 64'd3);
    chk("frame_ar_count", 64'(ar_log.size()), 64'd300);
    for (int i = 0; i < 300; i++)
      chk("frame_araddr", 64'(ar_log[i]), 64'(BASE + 32'(i) * 32'd512));
    chk("frame_last_addr", 64'(ar_log[299]), 64'h0102_5600);
    chk("frame_beats", 64'(beats_total), 64'd19200);
    chk("frame_exp_empty", 64'(exp_q.size()), 64'd0);
    chk("frame_rd_error", 64'(rd_error), 64'd0);
    chk("frame_burst_count", 64'(burst_count), 64'd300);

    // Delayed ARREADY
    do_reset();
    ar_delay = 5;
    sof_pulse();
    wait_ar(1, 200, "delay_ar_seen");
    chk("delay_arvalid_cycles", 64'(arv_len_log[0]), 64'd6);
    chk("delay_addr_stable", 64'(arv_unstable), 64'd0);
    chk("delay_araddr", 64'(ar_log[0]), 64'(BASE));
    chk("delay_no_early_beat", 64'(beats_at_hs[0]), 64'd0);
    wait_bc(9'd1, 200, "delay_burst_done");
    chk("delay_beats", 64'(beats_total), 64'd64);
    ar_delay = 0;

    // prog_full pause after three bursts
    do_reset();
    sof_pulse();
    wait_bc(9'd3, 1000, "pf_three_bursts");
    out_prog_full = 1'b1;
    chk("pf_ar_before", 64'(ar_log.size()), 64'd3);
    arv_seen = 0;
    repeat (100) begin
      @(negedge clk_100Mhz);
      if (bus.ARVALID) arv_seen++;
    end
    chk("pf_no_arvalid", 64'(arv_seen), 64'd0);
    chk("pf_state_idle", 64'(state), 64'd0);
    out_prog_full = 1'b0;
    lat = 0;
    do begin
      @(negedge clk_100Mhz);
      lat++;
    end while (!bus.ARVALID && lat < 10);
    chk("pf_resume_latency", 64'(lat), 64'd2);
    wait_ar(4, 20, "pf_burst4_seen");
    chk("pf_burst4_addr", 64'(ar_log[3]), 64'h0100_0600);

    // sof in the middle of burst 10
    do_reset();
    sof_pulse();
    n = 0;
    while (!(ar_log.size() == 11 && mon_beat >= 20) && n < 2000) begin
      @(negedge clk_100Mhz);
      n++;
    end
    chk("restart_at_beat20", 64'(mon_beat), 64'd20);
    sof_pulse();
    wait_ar(12, 300, "restart_next_ar");
    chk("restart_burst10_addr", 64'(ar_log[10]), 64'h0100_1400);
    chk("restart_addr_base", 64'(ar_log[11]), 64'(BASE));
    chk("restart_burst10_beats", 64'(beats_at_hs[11]), 64'd704);
    chk("restart_bc_zero", 64'(bc_at_hs[11]), 64'd0);
    wait_ar(13, 300, "restart_second_ar");
    chk("restart_bc_one", 64'(bc_at_hs[12]), 64'd1);
    chk("restart_second_addr", 64'(ar_log[12]), 64'h0100_0200);

    // Early RLAST in burst 1
    do_reset();
    rlast_bad_burst = 1;
    sof_pulse();
    wait_ar(2, 300, "rlast_ar1");
    chk("rlast_err_before", 64'(rd_error), 64'd0);
    wait_ar(3, 300, "rlast_ar2");
    chk("rlast_err_set", 64'(rd_error), 64'd1);
    chk("rlast_burst_len", 64'(beats_at_hs[2]), 64'd128);
    chk("rlast_next_addr", 64'(ar_log[2]), 64'h0100_0400);
    wait_bc(9'd4, 400, "rlast_continue");
    chk("rlast_err_sticky", 64'(rd_error), 64'd1);
    rlast_bad_burst = -1;

    // RRESP=SLVERR on one beat of burst 2
    do_reset();
    chk("rresp_err_cleared", 64'(rd_error), 64'd0);
    rresp_bad_burst = 2;
    sof_pulse();
    wait_bc(9'd2, 400, "rresp_two_bursts");
    chk("rresp_err_before", 64'(rd_error), 64'd0);
    wait_bc(9'd3, 200, "rresp_third_burst");
    chk("rresp_err_set", 64'(rd_error), 64'd1);
    chk("rresp_beats", 64'(beats_total), 64'd192);
    rresp_bad_burst = -1;

    // Reset during DATA_RECV
    do_reset();
    rlast_bad_burst = 0;
    sof_pulse();
    n = 0;
    while (!(ar_log.size() == 2 && state == 2'd2 && mon_beat >= 10) && n < 400) begin
      @(negedge clk_100Mhz);
      n++;
    end
    chk("midrst_in_burst", 64'(mon_beat), 64'd10);
    chk("midrst_err_before", 64'(rd_error), 64'd1);
    rst = 1'b1;
    @(negedge clk_100Mhz);
    chk("midrst_arvalid", 64'(bus.ARVALID), 64'd0);
    chk("midrst_rready", 64'(bus.RREADY), 64'd0);
    chk("midrst_burst_count", 64'(burst_count), 64'd0);
    chk("midrst_rd_error", 64'(rd_error), 64'd0);
    chk("midrst_state", 64'(state), 64'd0);
    @(negedge clk_100Mhz);
    clear_logs();
    rlast_bad_burst = -1;
    rst = 1'b0;
    repeat (200) @(negedge clk_100Mhz);
    chk("midrst_no_beats", 64'(beats_total), 64'd0);
    chk("midrst_no_ar", 64'(ar_log.size()), 64'd0);
    chk("midrst_wait_frame", 64'(state), 64'd3);
    sof_pulse();
    wait_bc(9'd1, 300, "midrst_resume");
    chk("midrst_resume_beats", 64'(beats_total), 64'd64);
    chk("midrst_resume_addr", 64'(ar_log[0]), 64'(BASE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_frame_reader.md
Name: axi4_frame_reader

Overview:
- AXI4 read master that fetches the frame buffer from DDR and streams it towards the HDMI output path.
- It reads the same 320x240 RGB565 frame the capture-side write master stores at FRAME_BASE_ADDR.
- The frame is read as 300 INCR bursts of 64 x 64-bit beats (512 bytes each), in address order.
- Read data is pushed into a downstream dual-clock FIFO (external); this block paces its requests on that FIFO's prog_full.

Parameters:
AXI_ADDR_WIDTH, 32, address bus width
AXI_DATA_WIDTH, 64, data bus width
FRAME_BASE_ADDR, 32'h0100_0000, DDR byte address of pixel 0
BURSTS_PER_FRAME, 300, bursts per frame (300 x 512 B = 153600 B)
BURST_BYTES, 512, address increment per burst

Ports:
clk_100Mhz  in  1  system/AXI clock
rst  in  1  asynchronous, active-high reset
frame_start  in  1  start-of-frame request from display timing (asynchronous level/pulse, synchronised inside)
ARADDR  out  32  read burst address
ARVALID  out  1  address valid
ARREADY  in  1  address accepted
ARLEN  out  8  constant 8'd63
ARSIZE  out  3  constant 3'b011
ARBURST  out  2  constant 2'b01 (INCR)
ARCACHE  out  4  constant 4'b1111
ARPROT  out  3  constant 3'b010
RDATA  in  64  read data
RVALID  in  1  read data valid
RREADY  out  1  read data ready
RLAST  in  1  last beat of burst
RRESP  in  2  read response
out_data  out  64  beat to downstream FIFO din
out_valid  out  1  downstream FIFO wr_en
out_prog_full  in  1  downstream FIFO cannot accept another 64 beats
burst_count  out  9  bursts completed in current frame
rd_error  out  1  sticky protocol/response error
state  out  2  FSM state for debug

Behaviour:
- Reset (async, active-high): state=IDLE, ARVALID=0, RREADY=0, ARADDR=FRAME_BASE_ADDR, burst_count=0, beat counter=0, rd_error=0, frame_armed=0, restart_pending=0.
- frame_start is passed through a 2-flop synchroniser, then a rising-edge detector; sof = 1-cycle pulse.
- States: IDLE=0, ADDR_SEND=1, DATA_RECV=2, WAIT_FRAME=3.
- WAIT_FRAME:
  - This is the entry state after reset (reset goes to IDLE with frame_armed=0, and IDLE moves to WAIT_FRAME next cycle).
  - On sof: burst_count=0, ARADDR=FRAME_BASE_ADDR, go to IDLE with frame_armed=1.
- IDLE:
  - If !out_prog_full and burst_count<BURSTS_PER_FRAME: go to ADDR_SEND.
  - If burst_count==BURSTS_PER_FRAME: go to WAIT_FRAME.
- ADDR_SEND:
  - ARVALID=1 the cycle after entry.
  - ARADDR is held stable while ARVALID=1.
  - On ARVALID&&ARREADY: ARVALID=0 next cycle, go to DATA_RECV.
- DATA_RECV:
  - RREADY=1 combinationally while state==DATA_RECV.
  - out_data=RDATA and out_valid=RVALID&&RREADY, both combinational (zero latency).
  - Each accepted beat increments the 6-bit beat counter.
  - RRESP!=2'b00 on any accepted beat sets rd_error.
  - RLAST on beat<63, or no RLAST on beat 63, sets rd_error.
  - The burst ends on the 64th accepted beat regardless of RLAST.
  - At burst end: beat counter=0, burst_count+1, ARADDR+=BURST_BYTES, go to IDLE.
- Backpressure: RREADY is never dropped mid-burst. The downstream FIFO must have at least 64 free entries whenever out_prog_full=0; this block relies on that.
- sof mid-frame:
  - In IDLE: applies immediately (burst_count=0, ARADDR=base).
  - In ADDR_SEND or DATA_RECV: sets restart_pending. The burst in flight completes normally (AXI bursts cannot be aborted), its beats are still forwarded, then counters reload to base and restart_pending clears.
- sof coinciding with burst end: the reload wins (burst_count=0, not 1).
- Address arithmetic: 32-bit unsigned, base + burst_count*512. The last burst of a frame starts at base+0x25600. No wrap inside a frame.
- rd_error clears only on rst.
- Reset mid-burst: FSM returns to IDLE immediately. Outstanding AXI beats are the interconnect's responsibility (rst is shared system-wide).
- Single outstanding read transaction at a time; no ID usage.

Test Plan:
- Reset, then sof, with ARREADY tied 1 and a memory model returning RDATA=beat index, out_prog_full=0 -> 300 AR handshakes at 0x0100_0000, 0x0100_0200 … 0x0102_5600; 19200 out_valid pulses; burst_count=300; state=3.
- ARREADY delayed 5 cycles -> ARVALID held high with ARADDR stable for 5 cycles; single handshake; no beat forwarded before it.
- out_prog_full=1 held 100 cycles after burst 3 -> no ARVALID during that time; burst 4 issued 2 cycles after deassertion at 0x0100_0600.
- sof at beat 20 of burst 10 -> all 64 beats of burst 10 forwarded; the next ARADDR is 0x0100_0000; burst_count reads 0 then 1.
- RLAST at beat 62, plus RRESP=2'b10 on one beat of another burst -> rd_error=1 after the first fault and remains 1; the burst still ends after 64 beats.
- rst asserted during DATA_RECV -> the next cycle shows ARVALID=0, RREADY=0, burst_count=0, rd_error=0; no out_valid until the next sof.
